// File: rtl/sd_loader_pkg.sv
// rtl/sd_loader_pkg.sv - shared state type and size constants for the SD ROM loader
package sd_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ISSUE,
    LD_RECEIVE,
    LD_BLOCK_END,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

  // Bytes returned by one SDIF block read.
  localparam int SD_BLOCK_BYTES = 512;

  // iNES image layout: header, PRG ROM, CHR ROM.
  localparam int INES_HEADER_BYTES = 16;
  localparam int INES_PRG_BYTES    = 32768;
  localparam int INES_CHR_BYTES    = 8192;
  localparam int INES_LOAD_BYTES   = INES_HEADER_BYTES + INES_PRG_BYTES + INES_CHR_BYTES;

endpackage

// File: rtl/sd_loader_watchdog.sv
// rtl/sd_loader_watchdog.sv - reloadable down-counter flagging a stalled transfer
module sd_loader_watchdog
  import sd_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded with TIMEOUT_CYCLES-1 so expiry is seen on the TIMEOUT_CYCLES-th edge after a reload.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: held at the reload value while disabled, otherwise counts down to zero and sticks.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || reload) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/sd_rom_loader.sv
// rtl/sd_rom_loader.sv - sequences SDIF block reads and writes the image into memory
module sd_rom_loader
  import sd_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          BLOCK_BYTES    = SD_BLOCK_BYTES,
  parameter int          LOAD_BYTES     = INES_LOAD_BYTES,
  parameter int          MEM_AW         = 16,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sd_idle,
  input  logic              sd_valid_read,
  input  logic [7:0]        sd_byte,
  output logic [31:0]       sd_addr,
  output logic              sd_begin_read,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TW = $clog2(LOAD_BYTES + BLOCK_BYTES + 1);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam logic [TW-1:0] LOAD_T  = TW'(LOAD_BYTES);
  localparam logic [BW-1:0] BLOCK_T = BW'(BLOCK_BYTES);
  localparam logic [31:0]   STEP    = 32'(BLOCK_BYTES);

  ld_state_e         state_q, state_d;
  logic [TW-1:0]     tot_q, tot_d;
  logic [BW-1:0]     blk_q, blk_d;
  logic [31:0]       addr_q, addr_d;
  logic              begin_q, begin_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic [7:0]        mdata_q, mdata_d;
  logic              we_q, we_d;
  logic              busy_q, done_q, error_q;
  logic              byte_in;
  logic              wd_reload;
  logic              wd_expired;

  sd_loader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .enable (busy_q),
    .reload (wd_reload),
    .expired(wd_expired)
  );

  // Next-state, counter and write-port logic for the load sequencer.
  always_comb begin
    state_d = state_q;
    tot_d   = tot_q;
    blk_d   = blk_q;
    addr_d  = addr_q;
    begin_d = begin_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    we_d    = 1'b0;
    byte_in = 1'b0;

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        begin_d = 1'b0;
        if (state_q == LD_IDLE) begin
          tot_d = '0;
          blk_d = '0;
        end
        if (start) begin
          state_d = LD_ISSUE;
          tot_d   = '0;
          blk_d   = '0;
          addr_d  = BASE_ADDR;
          begin_d = 1'b1;
        end
      end

      LD_ISSUE: begin
        if (!sd_idle) begin
          state_d = LD_RECEIVE;
          begin_d = 1'b0;
        end else if (wd_expired) begin
          state_d = LD_ERROR;
          begin_d = 1'b0;
        end else begin
          begin_d = 1'b1;
        end
      end

      LD_RECEIVE: begin
        if (sd_valid_read) begin
          byte_in = 1'b1;
          tot_d   = tot_q + 1'b1;
          blk_d   = blk_q + 1'b1;
          // Tail bytes of the final block beyond the image are counted but not stored.
          if (tot_q < LOAD_T) begin
            we_d    = 1'b1;
            maddr_d = MEM_AW'(tot_q);
            mdata_d = sd_byte;
          end
        end
        // The byte arriving with sd_idle is counted before the short-block check.
        if (blk_d == BLOCK_T) begin
          state_d = LD_BLOCK_END;
        end else if (sd_idle) begin
          state_d = LD_ERROR;
        end else if (wd_expired && !sd_valid_read) begin
          state_d = LD_ERROR;
        end
      end

      LD_BLOCK_END: begin
        if (sd_idle) begin
          blk_d = '0;
          if (tot_q >= LOAD_T) begin
            state_d = LD_DONE;
          end else begin
            state_d = LD_ISSUE;
            addr_d  = addr_q + STEP;
            begin_d = 1'b1;
          end
        end else if (wd_expired) begin
          state_d = LD_ERROR;
        end
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase

    wd_reload = (state_d != state_q) || byte_in;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LD_IDLE;
      tot_q   <= '0;
      blk_q   <= '0;
      addr_q  <= BASE_ADDR;
      begin_q <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      blk_q   <= blk_d;
      addr_q  <= addr_d;
      begin_q <= begin_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      we_q    <= we_d;
      busy_q  <= (state_d == LD_ISSUE) || (state_d == LD_RECEIVE) || (state_d == LD_BLOCK_END);
      done_q  <= (state_d == LD_DONE);
      error_q <= (state_d == LD_ERROR);
    end
  end

  assign sd_addr       = addr_q;
  assign sd_begin_read = begin_q;
  assign mem_addr      = maddr_q;
  assign mem_data      = mdata_q;
  assign mem_we        = we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
